sfifo_axis_out: RTL and testbench
=================================

SFIFO_AXIS_OUT -- requirements
Module: sfifo_axis_out

Interface
REQ-001 SHALL have parameter G_DATAWIDTH, default 32: width of the FIFO word and of m_tdata.
REQ-002 SHALL have parameter G_PKTLEN, default 16: beats per packet for m_tlast generation; legal range 1..65535.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all logic is rising-edge.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port flush, input, 1 bit: synchronous discard of all buffered and in-flight words.
REQ-006 SHALL have port fifo_rd_en, output, 1 bit: read strobe to the upstream non-FWFT sfifo.
REQ-007 SHALL have port fifo_dout, input, G_DATAWIDTH bits: sfifo read data, valid one cycle after an accepted read.
REQ-008 SHALL have port fifo_empty, input, 1 bit: sfifo empty flag.
REQ-009 SHALL have port m_tvalid, output, 1 bit: stream beat valid.
REQ-010 SHALL have port m_tready, input, 1 bit: downstream accept.
REQ-011 SHALL have port m_tdata, output, G_DATAWIDTH bits: stream beat data.
REQ-012 SHALL have port m_tlast, output, 1 bit: last beat of packet.
REQ-013 SHALL have port occupancy, output, 2 bits: number of words held in the skid buffer (0..3).

Function
REQ-014 SHALL hold words in a 3-entry in-order buffer; head entry drives m_tdata/m_tlast, m_tvalid = (occupancy != 0).
REQ-015 SHALL track one in-flight flag, set the cycle after fifo_rd_en=1, meaning fifo_dout is written into the buffer on that edge.
REQ-016 SHALL drive fifo_rd_en = ~fifo_empty & ~flush & (occupancy + inflight < 3); no combinational path from m_tready to fifo_rd_en.
REQ-017 SHALL pop the head when m_tvalid & m_tready; push and pop in the same cycle SHALL leave occupancy unchanged.
REQ-018 SHALL sustain one beat per clock with m_tready held high and fifo non-empty; first-word latency SHALL be 2 cycles from fifo_empty falling to m_tvalid rising.
REQ-019 SHALL hold m_tdata and m_tlast stable while m_tvalid=1 and m_tready=0.
REQ-020 SHALL never overflow: a buffer write with occupancy=3 and no pop is an assertion failure.
REQ-021 SHALL on flush=1: next edge set occupancy=0, clear inflight, discard the arriving fifo_dout word, reset beat counter; m_tvalid=0 the following cycle.
REQ-022 SHALL treat flush during a stalled handshake (m_tvalid=1, m_tready=0) as dropping that beat; the beat is not counted as transferred.
REQ-023 SHALL count accepted beats in a counter 0..G_PKTLEN-1, wrapping to 0 after G_PKTLEN-1.

Reset
REQ-024 SHALL while rst=0 asynchronously clear buffer pointers, occupancy, inflight and beat counter; m_tvalid=0, m_tlast=0, occupancy=0.
REQ-025 SHALL force fifo_rd_en=0 while rst=0, regardless of fifo_empty.
REQ-026 SHALL resume reads on the first rising edge after rst deasserts when fifo_empty=0; buffer data contents need not be reset.

Configuration
REQ-027 SHALL with SFIFO_AXIS_OUT_TLAST_EN defined drive m_tlast=1 on the head beat whose beat count equals G_PKTLEN-1, else 0.
REQ-028 SHALL without SFIFO_AXIS_OUT_TLAST_EN tie m_tlast to 0, omit the beat counter, and keep the port list unchanged.

Verification
REQ-029 SHALL cover: sfifo preloaded with 0x00..0x07, m_tready=1 -> m_tdata 0x00..0x07 on 8 consecutive cycles, first m_tvalid 2 cycles after release from reset.
REQ-030 SHALL cover: m_tready=0 with 10 words available -> exactly 3 fifo_rd_en pulses, occupancy=3, m_tdata=first word held; m_tready=1 -> order preserved, no loss.
REQ-031 SHALL cover: m_tready toggling 1010... over 20 words -> all 20 delivered in order, occupancy never exceeds 3, no overflow assertion.
REQ-032 SHALL cover: flush asserted with occupancy=2 and inflight=1 -> next cycle m_tvalid=0, occupancy=0, the in-flight word never appears on m_tdata.
REQ-033 SHALL cover (TLAST_EN, G_PKTLEN=4): 12 beats streamed -> m_tlast=1 on beats 3, 7, 11 only; flush after beat 5 restarts count so beat 9 of the resumed stream is not last.
REQ-034 SHALL cover: rst pulsed low mid-stream with occupancy=2 -> m_tvalid=0 and fifo_rd_en=0 during reset, occupancy=0 immediately.

Source files
------------

// File: rtl/sfifo_axis_out.sv
// Drains a non-FWFT sfifo into an AXI-Stream master through a 3-entry in-order skid buffer.
// Define SFIFO_AXIS_OUT_TLAST_EN to generate m_tlast every G_PKTLEN accepted beats.
module sfifo_axis_out #(
   parameter int G_DATAWIDTH = 32,
   parameter int G_PKTLEN    = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   flush,
   output logic                   fifo_rd_en,
   input  logic [G_DATAWIDTH-1:0] fifo_dout,
   input  logic                   fifo_empty,
   output logic                   m_tvalid,
   input  logic                   m_tready,
   output logic [G_DATAWIDTH-1:0] m_tdata,
   output logic                   m_tlast,
   output logic [1:0]             occupancy
);
   // Handshake: a beat transfers on a rising edge with m_tvalid & m_tready; m_tvalid never
   // depends on m_tready, and m_tdata/m_tlast hold while the beat is stalled.
   logic [G_DATAWIDTH-1:0] mem [3];
   logic [1:0]             wr_ptr;
   logic [1:0]             rd_ptr;
   logic [1:0]             occ;
   logic                   inflight;
   logic                   push;
   logic                   pop;

   function automatic logic [1:0] ptr_inc(input logic [1:0] p);
      return (p == 2'd2) ? 2'd0 : p + 2'd1;
   endfunction

   if (G_PKTLEN < 1 || G_PKTLEN > 65535) begin : g_bad_pktlen
      $error("sfifo_axis_out: G_PKTLEN must be in 1..65535");
   end

   assign push      = inflight & ~flush;
   assign pop       = m_tvalid & m_tready;
   assign m_tvalid  = (occ != 2'd0);
   assign m_tdata   = mem[rd_ptr];
   assign occupancy = occ;

   // Credit check uses registered state only, so m_tready never reaches the read strobe.
   assign fifo_rd_en = rst & ~fifo_empty & ~flush &
                       (({1'b0, occ} + {2'b00, inflight}) < 3'd3);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr   <= 2'd0;
         rd_ptr   <= 2'd0;
         occ      <= 2'd0;
         inflight <= 1'b0;
      end else if (flush) begin
         wr_ptr   <= 2'd0;
         rd_ptr   <= 2'd0;
         occ      <= 2'd0;
         inflight <= 1'b0;
      end else begin
         inflight <= fifo_rd_en;
         if (push) wr_ptr <= ptr_inc(wr_ptr);
         if (pop)  rd_ptr <= ptr_inc(rd_ptr);
         occ <= occ + {1'b0, push} - {1'b0, pop};
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= fifo_dout;
   end

   a_no_overflow: assert property (@(posedge clk) disable iff (!rst)
      !(push && (occ == 2'd3) && !pop));

`ifdef SFIFO_AXIS_OUT_TLAST_EN
   localparam int            CW       = (G_PKTLEN > 1) ? $clog2(G_PKTLEN) : 1;
   localparam logic [CW-1:0] LAST_CNT = CW'(G_PKTLEN - 1);
   logic [CW-1:0]            beat_cnt;

   // Counts beats accepted downstream; a beat dropped by flush never advances it.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         beat_cnt <= '0;
      end else if (flush) begin
         beat_cnt <= '0;
      end else if (pop) begin
         beat_cnt <= (beat_cnt == LAST_CNT) ? '0 : beat_cnt + CW'(1);
      end
   end

   assign m_tlast = m_tvalid & (beat_cnt == LAST_CNT);
`else
   assign m_tlast = 1'b0;
`endif

endmodule

// File: tb/tb_sfifo_axis_out.sv
// Self-checking bench for sfifo_axis_out: upstream sfifo model, scoreboard queue and a negedge monitor.
// Honours SFIFO_AXIS_OUT_TLAST_EN when it is defined for the build.
module tb_sfifo_axis_out;
   localparam int DW     = 32;
   localparam int PKTLEN = 4;
`ifdef SFIFO_AXIS_OUT_TLAST_EN
   localparam bit TLAST_EN = 1'b1;
`else
   localparam bit TLAST_EN = 1'b0;
`endif

   logic          clk        = 1'b0;
   logic          rst        = 1'b0;
   logic          flush      = 1'b0;
   logic          m_tready   = 1'b0;
   logic [DW-1:0] fifo_dout  = '0;
   logic          fifo_empty;
   logic          fifo_rd_en;
   logic          m_tvalid;
   logic          m_tlast;
   logic [DW-1:0] m_tdata;
   logic [1:0]    occupancy;

   logic [DW-1:0] src_q[$];
   logic [DW-1:0] exp_q[$];
   int            src_cnt    = 0;
   logic          rd_pending = 1'b0;
   logic          rd_prev    = 1'b0;
   int            rd_total   = 0;
   int            beat_cnt   = 0;
   int            tlast_seen = 0;
   int            checks     = 0;
   int            failures   = 0;
   logic          prev_stall = 1'b0;
   logic [DW-1:0] prev_data  = '0;
   logic          prev_last  = 1'b0;

   assign fifo_empty = (src_cnt == 0);

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   sfifo_axis_out #(.G_DATAWIDTH(DW), .G_PKTLEN(PKTLEN)) dut (
      .clk        (clk),
      .rst        (rst),
      .flush      (flush),
      .fifo_rd_en (fifo_rd_en),
      .fifo_dout  (fifo_dout),
      .fifo_empty (fifo_empty),
      .m_tvalid   (m_tvalid),
      .m_tready   (m_tready),
      .m_tdata    (m_tdata),
      .m_tlast    (m_tlast),
      .occupancy  (occupancy)
   );

   task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s: actual=0x%0h required=0x%0h at %0t", name, act, req, $time);
      end
   endtask

   // ---------------- upstream non-FWFT sfifo model ----------------
   always @(negedge clk) rd_pending = fifo_rd_en;

   always @(posedge clk) begin
      #1;
      rd_prev = rd_pending;
      if (rd_pending && src_q.size() > 0) begin
         fifo_dout = src_q.pop_front();
         src_cnt   = src_q.size();
         exp_q.push_back(fifo_dout);
         rd_total++;
      end
   end

   // ---------------- driver tasks ----------------
   task automatic push_word(input logic [DW-1:0] w);
      src_q.push_back(w);
      src_cnt = src_q.size();
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic flush_pulse();
      flush = 1'b1;
      step();
      flush = 1'b0;
   endtask

   task automatic wait_drain(input int budget);
      int n = 0;
      m_tready = 1'b1;
      while ((src_cnt != 0 || exp_q.size() != 0) && n < budget) begin
         step();
         n++;
      end
      check("drain_done", DW'(src_cnt + exp_q.size()), '0);
   endtask

   task automatic wait_occ(input logic [1:0] target, input int budget);
      int n = 0;
      while (occupancy != target && n < budget) begin
         step();
         n++;
      end
      check("occ_setup", occupancy, target);
   endtask

   // ---------------- monitor / scoreboard ----------------
   always @(negedge clk) begin
      int            exp_occ;
      logic          exp_last;
      logic [DW-1:0] exp_word;
      if (!rst) begin
         check("reset_occupancy", occupancy, '0);
         check("reset_tvalid", m_tvalid, '0);
         check("reset_rd_en", fifo_rd_en, '0);
         check("reset_tlast", m_tlast, '0);
         exp_q.delete();
         beat_cnt   = 0;
         prev_stall = 1'b0;
      end else begin
         // Words read upstream but not yet delivered live in the buffer or are in flight.
         exp_occ  = exp_q.size() - (rd_prev ? 1 : 0);
         exp_last = TLAST_EN && (beat_cnt == PKTLEN - 1);
         check("occupancy", occupancy, DW'(exp_occ));
         check("tvalid", m_tvalid, DW'(exp_occ != 0));
         check("rd_en", fifo_rd_en, DW'(!fifo_empty && !flush && exp_q.size() < 3));
         if (m_tvalid) check("tlast", m_tlast, exp_last);
         if (prev_stall) begin
            check("stall_tvalid", m_tvalid, 1'b1);
            check("stall_tdata", m_tdata, prev_data);
            check("stall_tlast", m_tlast, prev_last);
         end
         if (m_tvalid && m_tready) begin
            if (exp_q.size() == 0) begin
               check("unexpected_beat", m_tdata, 'x);
            end else begin
               exp_word = exp_q.pop_front();
               check("tdata", m_tdata, exp_word);
            end
            if (m_tlast) tlast_seen++;
            beat_cnt = (beat_cnt + 1) % PKTLEN;
         end
         prev_stall = m_tvalid && !m_tready && !flush;
         prev_data  = m_tdata;
         prev_last  = m_tlast;
         if (flush) begin
            exp_q.delete();
            beat_cnt = 0;
         end
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      int            lat;
      logic [DW-1:0] first_w;
      int            rd0;
      int            n;

      // Preloaded sfifo, stream out after reset release.
      for (int i = 0; i < 8; i++) push_word(DW'(i));
      repeat (3) step();
      m_tready = 1'b1;
      rst      = 1'b1;
      lat      = 0;
      while (!m_tvalid && lat < 10) begin
         step();
         lat++;
      end
      check("first_word_latency", DW'(lat), DW'(2));
      for (int i = 0; i < 8; i++) begin
         check("burst_tvalid", m_tvalid, 1'b1);
         check("burst_tdata", m_tdata, DW'(i));
         step();
      end
      wait_drain(50);

      // Downstream stalled with 10 words available.
      m_tready = 1'b0;
      first_w  = $urandom();
      rd0      = rd_total;
      push_word(first_w);
      for (int i = 1; i < 10; i++) push_word($urandom());
      repeat (12) @(negedge clk);
      check("stall_rd_pulses", DW'(rd_total - rd0), DW'(3));
      check("stall_occupancy", occupancy, DW'(3));
      check("stall_head", m_tdata, first_w);
      step();
      wait_drain(100);

      // m_tready toggling 1010... over 20 words.
      m_tready = 1'b0;
      for (int i = 0; i < 20; i++) push_word($urandom());
      n = 0;
      while ((src_cnt != 0 || exp_q.size() != 0) && n < 100) begin
         m_tready = ~m_tready;
         step();
         n++;
      end
      wait_drain(50);

      // Flush with two buffered words and one in flight.
      m_tready = 1'b0;
      for (int i = 0; i < 5; i++) push_word(DW'(32'hA0 + i));
      wait_occ(2'd2, 10);
      flush_pulse();
      check("flush_tvalid", m_tvalid, '0);
      check("flush_occupancy", occupancy, '0);
      wait_drain(50);

      // Packet framing, then a flush after beat 5 restarting the count.
      flush_pulse();
      tlast_seen = 0;
      for (int i = 0; i < 12; i++) push_word($urandom());
      wait_drain(50);
      check("tlast_count_12", DW'(tlast_seen), TLAST_EN ? DW'(3) : DW'(0));
      for (int i = 0; i < 6; i++) push_word($urandom());
      wait_drain(50);
      flush_pulse();
      tlast_seen = 0;
      for (int i = 0; i < 10; i++) push_word($urandom());
      wait_drain(50);
      check("tlast_count_resumed", DW'(tlast_seen), TLAST_EN ? DW'(2) : DW'(0));

      // Reset pulsed mid-stream with two words buffered.
      m_tready = 1'b0;
      for (int i = 0; i < 6; i++) push_word($urandom());
      wait_occ(2'd2, 10);
      rst = 1'b0;
      #1;
      check("rst_occupancy_now", occupancy, '0);
      check("rst_tvalid_now", m_tvalid, '0);
      check("rst_rd_en_now", fifo_rd_en, '0);
      repeat (2) step();
      rst = 1'b1;
      wait_drain(50);

      // Randomized traffic with random backpressure and occasional flushes.
      for (int c = 0; c < 400; c++) begin
         if ($urandom_range(0, 3) != 0 && src_cnt < 8) push_word($urandom());
         if ($urandom_range(0, 5) == 0) push_word($urandom());
         m_tready = ($urandom_range(0, 2) != 0);
         flush    = ($urandom_range(0, 29) == 0);
         step();
      end
      flush = 1'b0;
      wait_drain(200);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #500000;
      failures++;
      $display("FAIL watchdog: simulation time limit reached");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog");
   end

endmodule
